sevenseg_decoder: RTL and testbench
===================================

// Module: sevenseg_decoder
// PURPOSE
//  Loopback/monitor receiver for the multiplexed 7-segment bus: samples an/seg/dp (all active-low),
//  decodes each scanned digit back to a 4-bit value + dp, debounces over repeated scans and
//  presents per-digit registers. Sits beside the display mux for self-check and score readback.
// PARAMETERS
//  SETTLE_CYC   4       clk cycles an must be stable before seg/dp are sampled (>=1)
//  STABLE_OBS   2       consecutive identical observations of a digit required to commit (>=1)
//  TIMEOUT_CYC  262144  cycles without an observation of digit i before valid[i] clears
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  an         in   4  digit enables, active-low, bit i = digit i
//  seg        in   7  segments {G,F,E,D,C,B,A}, active-low
//  dp         in   1  decimal point, active-low
//  err_clr    in   1  1-cycle pulse, clears sticky error flags
//  d0..d3     out  4  committed digit values (blank = 4'hF)
//  dp0..dp3   out  1  committed decimal points, active-high (1 = lit)
//  valid      out  4  digit i committed and not timed out
//  blank      out  4  digit i committed as all-segments-off
//  update     out  1  1-cycle pulse when any committed value/dp/blank changes
//  err_multi  out  1  sticky: >1 an bit low seen
//  err_glyph  out  1  sticky: undecodable segment pattern committed
// BEHAVIOUR
//  - Reset (async assert, sync release): d*=4'hF, dp*=0, valid=0, blank=0, update=0, err_*=0,
//    FSM=IDLE, all counters 0, candidates cleared.
//  - an/seg/dp registered once on entry; all logic below uses registered copies.
//  - FSM: IDLE (an=4'b1111) / SETTLE / HOLD.
//    any state, an one-cold with digit k and an != previous an -> SETTLE, settle_cnt=0.
//    SETTLE: an unchanged -> settle_cnt++; at settle_cnt==SETTLE_CYC-1 sample seg/dp -> HOLD.
//    HOLD: wait for an change. an=4'b1111 -> IDLE. >1 an bit low -> set err_multi, IDLE, no sample.
//  - Decode: 0-9 per standard active-low glyphs (0=1000000 ... 9=0010000); 1111111 -> blank, 4'hF;
//    other patterns -> invalid glyph.
//  - Per digit: candidate {val,dp,blank,inv} + match_cnt (saturates at STABLE_OBS).
//    Sample equal to candidate -> match_cnt++; else candidate=sample, match_cnt=1.
//    match_cnt reaching STABLE_OBS commits: outputs updated the cycle after sample edge.
//    Commit of invalid glyph: valid[k]=0, err_glyph=1, d/dp unchanged.
//    Commit of valid glyph: d,dp,blank,valid[k]=1; update pulses iff value/dp/blank/valid changed.
//  - Latency pin->commit (STABLE_OBS=1): 1 + SETTLE_CYC + 1 cycles.
//  - Timeout: per-digit counter reset on each sample of that digit; reaching TIMEOUT_CYC-1 clears
//    valid[k] (d unchanged), pulses update if valid was 1, counter holds (no wrap).
//    Counter width $clog2(TIMEOUT_CYC).
//  - err_clr and new error same cycle: error wins (flag stays 1).
//  - an changing mid-SETTLE: aborts sample, restarts SETTLE for new digit; no observation logged.
//  - Reset mid-operation: everything returns to reset values immediately.
// CONFIGURATION
//  SEVENSEG_DEC_HEX_EN defined: glyphs A-F (0001000,0000011,1000110,0100001,0000110,0001110)
//    decode to 4'hA-4'hF with blank=0; blank glyph still 4'hF with blank=1.
//  Undefined: those six patterns are invalid glyphs (err_glyph path).
// TESTING
//  1 reset: rst_n low mid-activity -> d*=F, valid=0, err_*=0 same cycle, FSM IDLE.
//  2 digit 0 shows 7 (an=1110, seg=1111000), dp=0, held 20 cyc, re-scanned once (defaults)
//    -> d0=7, dp0=1, valid=0001, one update pulse.
//  3 an glitches to 1101 for 2 cycles (< SETTLE_CYC) -> no sample, d1 unchanged, no update.
//  4 digits 2,3 never selected for 262144 cycles after commit -> valid[3:2]=00, one update pulse.
//  5 an=1100 -> err_multi=1, held until err_clr; err_clr -> 0 next cycle.
//  6 seg=0001000 on digit 1 twice: HEX_EN -> d1=A valid; else err_glyph=1, valid[1]=0.

Source files
------------

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: samples a multiplexed active-low 7-segment bus and commits debounced per-digit values.
// Define SEVENSEG_DEC_HEX_EN to decode the A-F glyphs; otherwise they are reported as invalid glyphs.
module sevenseg_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int STABLE_OBS  = 2,
    parameter int TIMEOUT_CYC = 262144
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic       err_clr,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       dp0,
    output logic       dp1,
    output logic       dp2,
    output logic       dp3,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic       update,
    output logic       err_multi,
    output logic       err_glyph
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam int MW = $clog2(STABLE_OBS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t        state, state_n;
    logic [3:0]    an_s, an_p;
    logic [6:0]    seg_s;
    logic          dp_s;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [1:0]    dig, dig_n;
    logic [6:0]    cand [4];
    logic [MW-1:0] match_cnt [4];
    logic [TW-1:0] to_cnt [4];
    logic [3:0]    dv [4];
    logic [3:0]    dpv;
    logic [2:0]    lows;
    logic          chg, sample, multi_set;
    logic [5:0]    dec;
    logic [6:0]    smp;
    logic          eq, commit, cinv, cchg;
    logic [MW-1:0] mc_n;
    logic [3:0]    to_hit;

    // returns {value, blank, invalid}
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = {4'h0, 2'b00};
            7'h79: decode = {4'h1, 2'b00};
            7'h24: decode = {4'h2, 2'b00};
            7'h30: decode = {4'h3, 2'b00};
            7'h19: decode = {4'h4, 2'b00};
            7'h12: decode = {4'h5, 2'b00};
            7'h02: decode = {4'h6, 2'b00};
            7'h78: decode = {4'h7, 2'b00};
            7'h00: decode = {4'h8, 2'b00};
            7'h10: decode = {4'h9, 2'b00};
`ifdef SEVENSEG_DEC_HEX_EN
            7'h08: decode = {4'hA, 2'b00};
            7'h03: decode = {4'hB, 2'b00};
            7'h46: decode = {4'hC, 2'b00};
            7'h21: decode = {4'hD, 2'b00};
            7'h06: decode = {4'hE, 2'b00};
            7'h0E: decode = {4'hF, 2'b00};
`endif
            7'h7F: decode = {4'hF, 2'b10};
            default: decode = {4'hF, 2'b01};
        endcase
    endfunction

    assign lows = 3'($countones(~an_s));
    assign chg  = an_s != an_p;

    always_comb begin
        state_n    = state;
        settle_n   = settle_cnt;
        dig_n      = dig;
        sample     = 1'b0;
        multi_set  = 1'b0;
        if (chg) begin
            if (lows == 3'd1) begin
                state_n  = SETTLE;
                settle_n = '0;
                dig_n    = !an_s[0] ? 2'd0 : !an_s[1] ? 2'd1 : !an_s[2] ? 2'd2 : 2'd3;
            end else begin
                state_n   = IDLE;
                multi_set = lows > 3'd1;
            end
        end else if (state == SETTLE) begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                sample  = 1'b1;
                state_n = HOLD;
            end else begin
                settle_n = settle_cnt + 1'b1;
            end
        end
    end

    assign dec    = decode(seg_s);
    assign smp    = {dec[5:2], ~dp_s, dec[1], dec[0]};
    assign cinv   = dec[0];
    assign eq     = match_cnt[dig] != '0 && cand[dig] == smp;
    assign mc_n   = !eq ? MW'(1) : match_cnt[dig] == MW'(STABLE_OBS) ? match_cnt[dig] : match_cnt[dig] + 1'b1;
    assign commit = sample && mc_n == MW'(STABLE_OBS);
    assign cchg   = commit && (cinv ? valid[dig] :
                    (dv[dig] != dec[5:2] || dpv[dig] != ~dp_s || blank[dig] != dec[1] || !valid[dig]));

    // a sample of the digit keeps it alive, so it suppresses the timeout that cycle
    always_comb begin
        to_hit = '0;
        for (int k = 0; k < 4; k++)
            to_hit[k] = to_cnt[k] == TMAX && valid[k] && !(sample && dig == 2'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            an_s       <= '1;
            an_p       <= '1;
            seg_s      <= '1;
            dp_s       <= 1'b1;
            settle_cnt <= '0;
            dig        <= '0;
            for (int k = 0; k < 4; k++) begin
                cand[k]      <= '0;
                match_cnt[k] <= '0;
                to_cnt[k]    <= '0;
                dv[k]        <= 4'hF;
            end
            dpv        <= '0;
            valid      <= '0;
            blank      <= '0;
            update     <= 1'b0;
            err_multi  <= 1'b0;
            err_glyph  <= 1'b0;
        end else begin
            an_s       <= an;
            an_p       <= an_s;
            seg_s      <= seg;
            dp_s       <= dp;
            state      <= state_n;
            settle_cnt <= settle_n;
            dig        <= dig_n;
            update     <= cchg | (|to_hit);
            err_multi  <= multi_set | (err_multi & ~err_clr);
            err_glyph  <= (commit & cinv) | (err_glyph & ~err_clr);
            for (int k = 0; k < 4; k++) begin
                to_cnt[k] <= (sample && dig == 2'(k)) ? '0 : to_cnt[k] == TMAX ? to_cnt[k] : to_cnt[k] + 1'b1;
                if (to_hit[k]) valid[k] <= 1'b0;
            end
            if (sample) begin
                cand[dig]      <= smp;
                match_cnt[dig] <= mc_n;
            end
            if (commit) begin
                if (cinv) begin
                    valid[dig] <= 1'b0;
                end else begin
                    dv[dig]    <= dec[5:2];
                    dpv[dig]   <= ~dp_s;
                    blank[dig] <= dec[1];
                    valid[dig] <= 1'b1;
                end
            end
        end
    end

    assign d0  = dv[0];
    assign d1  = dv[1];
    assign d2  = dv[2];
    assign d3  = dv[3];
    assign dp0 = dpv[0];
    assign dp1 = dpv[1];
    assign dp2 = dpv[2];
    assign dp3 = dpv[3];
endmodule

// File: tb/tb_sevenseg_decoder.sv
// tb_sevenseg_decoder: randomized scans against a glyph-table reference model with an update-driven scoreboard.
module tb_sevenseg_decoder;
    localparam int S = 4;
    localparam int O = 2;
    localparam int T = 400;
`ifdef SEVENSEG_DEC_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an = 4'hF;
    logic [6:0] seg = 7'h7F;
    logic       dp = 1'b1;
    logic       err_clr = 1'b0;
    logic [3:0] d0, d1, d2, d3, valid, blank;
    logic       dp0, dp1, dp2, dp3, update, err_multi, err_glyph;

    always #5 clk = ~clk;

    sevenseg_decoder #(.SETTLE_CYC(S), .STABLE_OBS(O), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp), .err_clr(err_clr),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp0(dp0), .dp1(dp1), .dp2(dp2), .dp3(dp3),
        .valid(valid), .blank(blank), .update(update), .err_multi(err_multi), .err_glyph(err_glyph)
    );

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [27:0] exp_q [$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] md [4];
    logic [3:0] mdp, mvalid, mblank;
    logic       merr_g;
    logic [6:0] mcand [4];
    int         mcnt [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [27:0] dut_snap();
        return {d3, d2, d1, d0, dp3, dp2, dp1, dp0, valid, blank};
    endfunction

    function automatic logic [27:0] model_snap();
        return {md[3], md[2], md[1], md[0], mdp, mvalid, mblank};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            md[k] = 4'hF;
            mcand[k] = '0;
            mcnt[k] = 0;
        end
        mdp = '0;
        mvalid = '0;
        mblank = '0;
        merr_g = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_sample(input int k, input logic [6:0] s, input logic p);
        logic [3:0] v;
        logic b, inv;
        logic [6:0] t;
        v = 4'hF; b = 1'b0; inv = 1'b1;
        if (s == 7'h7F) begin b = 1'b1; inv = 1'b0; end
        for (int i = 0; i < 16; i++)
            if (glyph[i] == s && (i < 10 || HEX)) begin v = 4'(i); inv = 1'b0; end
        t = {v, ~p, b, inv};
        if (mcnt[k] > 0 && mcand[k] == t) mcnt[k] = mcnt[k] < O ? mcnt[k] + 1 : O;
        else begin mcand[k] = t; mcnt[k] = 1; end
        if (mcnt[k] == O) begin
            if (inv) begin
                merr_g = 1'b1;
                if (mvalid[k]) begin mvalid[k] = 1'b0; exp_q.push_back(model_snap()); end
            end else if (md[k] != v || mdp[k] != ~p || mblank[k] != b || !mvalid[k]) begin
                md[k] = v; mdp[k] = ~p; mblank[k] = b; mvalid[k] = 1'b1;
                exp_q.push_back(model_snap());
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int k, input logic [6:0] s, input logic p, input int hold);
        an = ~(4'(1) << k); seg = s; dp = p;
        model_sample(k, s, p);
        cyc(hold);
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        cyc(2);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && update) begin
            upd_cnt++;
            if (exp_q.size() == 0) check("spurious_update", 32'd1, 32'd0);
            else check("update_snapshot", 32'(dut_snap()), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] last_g [4];
        logic       last_p [4];
        logic [6:0] g;
        logic       p;
        int         u0;
        model_reset();
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("reset_snapshot", 32'(dut_snap()), 32'(model_snap()));
        check("reset_errors", {30'd0, err_multi, err_glyph}, 32'd0);

        // single-digit 7 with dp lit, re-scanned once
        u0 = upd_cnt;
        scan(0, 7'h78, 1'b0, 20);
        scan(0, 7'h78, 1'b0, 20);
        check("digit0_value", {28'd0, d0}, 32'h7);
        check("digit0_dp", {31'd0, dp0}, 32'd1);
        check("digit0_valid", {28'd0, valid}, 32'b0001);
        check("digit0_updates", 32'(upd_cnt - u0), 32'd1);

        // short glitch on digit 1 never reaches the sample point
        u0 = upd_cnt;
        an = 4'b1101; seg = 7'h00; dp = 1'b0;
        cyc(2);
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        cyc(8);
        check("glitch_no_update", 32'(upd_cnt - u0), 32'd0);
        check("glitch_snapshot", 32'(dut_snap()), 32'(model_snap()));

        // multiple digits low, sticky until cleared, set beats clear
        an = 4'b1100;
        cyc(3);
        check("multi_set", {31'd0, err_multi}, 32'd1);
        an = 4'hF;
        cyc(3);
        check("multi_held", {31'd0, err_multi}, 32'd1);
        pulse_clr();
        check("multi_cleared", {31'd0, err_multi}, 32'd0);
        an = 4'b1100;
        cyc(1);
        pulse_clr();
        check("multi_wins_clear", {31'd0, err_multi}, 32'd1);
        an = 4'hF;
        cyc(3);

        // asynchronous reset mid-scan
        an = 4'b1011; seg = 7'h12; dp = 1'b0;
        cyc(3);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_snapshot", 32'(dut_snap()), {16'hFFFF, 12'h000});
        check("midreset_flags", {29'd0, update, err_multi, err_glyph}, 32'd0);
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // randomized round-robin scans
        for (int k = 0; k < 4; k++) begin last_g[k] = 7'h7F; last_p[k] = 1'b1; end
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    g = last_g[k]; p = last_p[k];
                end else begin
                    case ($urandom_range(0, 7))
                        0, 1, 2, 3: g = glyph[$urandom_range(0, 9)];
                        4:          g = 7'h7F;
                        5:          g = glyph[$urandom_range(10, 15)];
                        default:    g = 7'($urandom);
                    endcase
                    p = 1'($urandom_range(0, 1));
                end
                last_g[k] = g; last_p[k] = p;
                scan(k, g, p, 8 + $urandom_range(0, 6));
            end
        end
        cyc(4);
        check("random_snapshot", 32'(dut_snap()), 32'(model_snap()));
        check("random_err_glyph", {31'd0, err_glyph}, {31'd0, merr_g});
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);

        // digits 2 and 3 starve and time out, 2 first
        for (int r = 0; r < 2; r++) begin
            scan(0, glyph[5], 1'b0, 8);
            scan(1, glyph[8], 1'b1, 8);
        end
        for (int k = 2; k < 4; k++)
            if (mvalid[k]) begin mvalid[k] = 1'b0; exp_q.push_back(model_snap()); end
        for (int r = 0; r < 40; r++) begin
            scan(0, glyph[5], 1'b0, 8);
            scan(1, glyph[8], 1'b1, 8);
        end
        check("timeout_valid", {30'd0, valid[3:2]}, 32'd0);
        check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
        check("timeout_values", 32'(dut_snap()), 32'(model_snap()));

        // hex A glyph on digit 1
        pulse_clr();
        merr_g = 1'b0;
        check("glyph_err_cleared", {31'd0, err_glyph}, 32'd0);
        scan(1, 7'h08, 1'b1, 8);
        scan(1, 7'h08, 1'b1, 8);
        check("hex_err_glyph", {31'd0, err_glyph}, HEX ? 32'd0 : 32'd1);
        check("hex_valid1", {31'd0, valid[1]}, HEX ? 32'd1 : 32'd0);
        check("hex_snapshot", 32'(dut_snap()), 32'(model_snap()));
        cyc(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
